char_spawner: RTL and testbench
===============================

# char_spawner

Generates falling characters for the typing game and feeds the VGA character renderer's write port. On a mode-dependent frame interval it draws a pseudo-random column, ASCII letter and velocity from an LFSR. It checks the renderer's `wr_ready` for that column and retries on an occupied slot. It then holds `vmdata_wren` and its data stable for one full frame, so the renderer latches them at its next frame-start write slot.

## Interface
Parameters:
- `MAX_TRIES`, 4: column picks per spawn attempt before the spawn is dropped.
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: single clock; the 50 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `v_end` in 1: end-of-frame level from the VGA timing. A frame tick is its rising edge, detected internally.
- `pause` in 1: low pauses spawning.
- `mode` in 2: difficulty. Interval is 32 − 8·mode frames (32/24/16/8).
- `wr_ready` in 1: from the renderer; high means the slot at `vmdata_wraddr` is empty. Valid one cycle after the address changes.
- `vmdata_wr` out 8: ASCII code to write.
- `vmdata_wraddr` out 6: column, 1..52.
- `vmdata_wren` out 1: write request.
- `veldata_wr` out 8: velocity byte. The renderer uses bits[1:0]+1.
- `spawn_count` out 14: successful spawns. Wraps.
- `drop_count` out 8: dropped spawns. Saturates at 255.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (mask 16'hB400). It shifts every clock, including while paused.
- Frame tick: `v_end & ~v_end_q`, where `v_end_q` is registered `v_end`.
- States: IDLE, PICK, CHECK, HOLD.
- **IDLE**
  - `frames_left` decrements on each frame tick while `pause`=1.
  - A frame tick with `frames_left`=0 goes to PICK with `tries`=0.
  - Paused means no decrement and no spawn.
- **PICK** (one cycle): registers the column, letter and velocity, then goes to CHECK.
  - Column: c=lfsr[5:0]; if c≥52 use c−52; add 1. Result is 1..52.
  - Letter: l=lfsr[12:8]; if l≥26 use l−26; add 8'h61 (lower-case a..z).
  - Velocity: lfsr[15:8].
- **CHECK** (one cycle): samples `wr_ready`.
  - If 1: assert `vmdata_wren`, increment `spawn_count`, go to HOLD.
  - If 0: increment `tries`. If `tries` now equals `MAX_TRIES`, increment `drop_count` (saturating) and go to IDLE. Otherwise go back to PICK.
- **HOLD**: `vmdata_wren`=1, and all data outputs are frozen.
  - The second frame tick after entry deasserts `wren` and goes to IDLE. This guarantees exactly one full renderer frame-start slot inside the hold.
  - `pause` does not abort HOLD.
- Reload: on every entry to IDLE, `frames_left` = 31 − 8·mode, so `mode` is sampled only at reload.
- Simultaneous events:
  - A frame tick in PICK or CHECK is ignored. It does not count toward HOLD.
  - A frame tick in the same cycle as the CHECK→HOLD transition does not count.

## Timing
- Reset values: all outputs 0; state IDLE; `frames_left` = 31 − 8·mode; LFSR = `SEED`.
- Reset mid-HOLD drops `vmdata_wren` asynchronously.
- Best-case latency from the spawn frame tick to `vmdata_wren`: 2 clocks (PICK, CHECK).
- Each retry adds 2 clocks.
- All outputs are registered. There is no combinational path from any input to any output.
- `vmdata_wr`, `vmdata_wraddr` and `veldata_wr` change only in PICK, and `vmdata_wren` is 0 whenever they change.
- The first spawn after reset occurs on the (32−8·mode)-th unpaused frame tick.

## Configuration
- `SPAWN_UPPERCASE_EN`
  - Defined: in PICK, lfsr[13]=1 selects upper case (base 8'h41 instead of 8'h61). All other behaviour is unchanged.
  - Undefined: lower case only. lfsr[13] is unused.

## Structure
- Shared package `typing_pkg`:
  - `NUM_COLS`=53, `FIRST_COL`=1, `LAST_COL`=52.
  - `ASCII_LOWER_A`=8'h61, `ASCII_UPPER_A`=8'h41.
  - `LFSR_MASK`=16'hB400.
  - `spawn_state_t` enum {IDLE, PICK, CHECK, HOLD}.
  - `interval_frames(mode)` function.
- Sub-module: `lfsr16`, with ports `clk`, `reset`, seed parameter and `q[15:0]`. The parent owns the FSM and counters.

## Test plan
- mode=0, pause=1, `wr_ready` tied 1, reset released: first `vmdata_wren` exactly 2 clocks after the 32nd frame tick. Address in 1..52, data in 8'h61..8'h7A. `spawn_count`=1.
- `wren` hold: `vmdata_wren` stays 1 with data stable until the second frame tick after assertion, then drops. The next spawn comes 32 frame ticks after that.
- mode=3: successive `wren` rising edges spaced 2 frames (HOLD) + 8 frames. `mode` changed mid-interval takes effect only at the next reload.
- `wr_ready` tied 0: 4 PICK/CHECK pairs (8 clocks), then `drop_count` increments. After 300 attempts `drop_count`=255. `vmdata_wren` never asserts.
- pause=0 for 100 frames mid-countdown: no spawn, `frames_left` frozen. Resume completes the remaining count. pause=0 during HOLD does not shorten it.
- Reset asserted during HOLD: `vmdata_wren` and all counters go 0 immediately. Run with and without `SPAWN_UPPERCASE_EN` and check 8'h41..8'h5A codes appear only when defined.

Source files
------------

// File: rtl/typing_pkg.sv
// typing_pkg
// Shared constants, state encoding and helpers for the typing-game
// character path (spawner and renderer write port).
//   NUM_COLS / FIRST_COL / LAST_COL : renderer column space (column 0 unused)
//   ASCII_LOWER_A / ASCII_UPPER_A   : letter bases
//   LFSR_MASK                       : Galois taps for x^16+x^14+x^13+x^11
//   spawn_state_t                   : spawner FSM encoding
//   interval_frames()               : spawn interval in frames for a mode
`timescale 1ns/1ps
package typing_pkg;

    localparam int NUM_COLS = 53;
    localparam int COL_W    = $clog2(NUM_COLS);

    localparam logic [COL_W-1:0] FIRST_COL = 6'd1;
    localparam logic [COL_W-1:0] LAST_COL  = 6'd52;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [4:0] NUM_LETTERS   = 5'd26;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        CHECK,
        HOLD
    } spawn_state_t;

    // 32 - 8*mode: 32/24/16/8 frames
    function automatic logic [5:0] interval_frames(input logic [1:0] mode);
        return 6'd32 - {1'b0, mode, 3'b000};
    endfunction

    // Folds a 6-bit random value onto columns FIRST_COL..LAST_COL
    function automatic logic [COL_W-1:0] col_from_rand(input logic [COL_W-1:0] r);
        logic [COL_W-1:0] c;
        c = (r >= LAST_COL) ? r - LAST_COL : r;
        return c + FIRST_COL;
    endfunction

    // Folds a 5-bit random value onto a..z (or A..Z when upper is set)
    function automatic logic [7:0] letter_from_rand(input logic [4:0] r, input logic upper);
        logic [4:0] l;
        l = (r >= NUM_LETTERS) ? r - NUM_LETTERS : r;
        return (upper ? ASCII_UPPER_A : ASCII_LOWER_A) + {3'b000, l};
    endfunction

endpackage

// File: rtl/char_spawner_if.sv
// char_spawner_if
// Renderer write port carrying a spawned character.
//   wr_ready      : renderer -> spawner, slot at vmdata_wraddr is empty
//   vmdata_wr     : ASCII code
//   vmdata_wraddr : column 1..52
//   vmdata_wren   : write request, held for one full frame
//   veldata_wr    : velocity byte
// Modports: master (spawner side), slave (renderer side).
`timescale 1ns/1ps
interface char_spawner_if;
    import typing_pkg::*;

    logic             wr_ready;
    logic [7:0]       vmdata_wr;
    logic [COL_W-1:0] vmdata_wraddr;
    logic             vmdata_wren;
    logic [7:0]       veldata_wr;

    modport master (
        input  wr_ready,
        output vmdata_wr,
        output vmdata_wraddr,
        output vmdata_wren,
        output veldata_wr
    );

    modport slave (
        output wr_ready,
        input  vmdata_wr,
        input  vmdata_wraddr,
        input  vmdata_wren,
        input  veldata_wr
    );

endinterface

// File: rtl/char_spawner_lfsr16.sv
// lfsr16
// Free-running 16-bit Galois LFSR (right shift, taps LFSR_MASK).
// Shifts every clock.
//   clk   : system clock
//   reset : asynchronous active-low reset, loads SEED
//   q     : current LFSR state
`timescale 1ns/1ps
module lfsr16
    import typing_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/char_spawner.sv
// char_spawner
// Spawns falling characters for the typing game. Every interval_frames(mode)
// unpaused frames it draws a column, letter and velocity from an LFSR, asks
// the renderer whether that column is free (retrying up to MAX_TRIES picks)
// and then holds the write request stable across one full renderer frame.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   v_end       : end-of-frame level; its rising edge is the frame tick
//   pause       : low pauses the countdown (an ongoing hold still completes)
//   mode        : difficulty, interval 32/24/16/8 frames
//   vm          : renderer write port (char_spawner_if.master)
//   spawn_count : successful spawns, wraps
//   drop_count  : dropped spawns, saturates at 255
// Build option: SPAWN_UPPERCASE_EN lets lfsr[13] select upper-case letters.
//
// state | meaning
// IDLE  | counting frame ticks down to the next spawn
// PICK  | register column, letter and velocity from the LFSR
// CHECK | sample wr_ready for the registered column
// HOLD  | vmdata_wren high, data frozen, waiting for the second frame tick
`timescale 1ns/1ps
module char_spawner
    import typing_pkg::*;
#(
    parameter int          MAX_TRIES = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           v_end,
    input  logic           pause,
    input  logic [1:0]     mode,
    char_spawner_if.master vm,
    output logic [13:0]    spawn_count,
    output logic [7:0]     drop_count
);

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);

    spawn_state_t     state_q, state_d;
    logic [15:0]      lfsr_q;
    logic             v_end_q;
    logic             frame_tick;
    logic [4:0]       frames_left;
    logic [4:0]       frames_cur;
    logic [4:0]       reload_val;
    logic             reload_q;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_inc;
    logic             hold_seen;

    logic             wren_q;
    logic [COL_W-1:0] addr_q;
    logic [7:0]       data_q;
    logic [7:0]       vel_q;

    logic             pick_upper;
    logic [COL_W-1:0] pick_addr;
    logic [7:0]       pick_data;
    logic             lfsr_unused;

    logic do_reload, do_dec, do_pick, do_clr_tries, do_inc_try;
    logic do_spawn, do_drop, do_mark_hold, do_end_hold;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign frame_tick = v_end & ~v_end_q;
    assign reload_val = 5'(interval_frames(mode) - 6'd1);
    // Right after reset the countdown has not been loaded yet; use the
    // reload value directly so a tick in the first cycle still counts.
    assign frames_cur = reload_q ? reload_val : frames_left;
    assign tries_inc  = tries + TRY_W'(1);

`ifdef SPAWN_UPPERCASE_EN
    assign pick_upper = lfsr_q[13];
`else
    assign pick_upper = 1'b0;
`endif
    assign pick_addr   = col_from_rand(lfsr_q[5:0]);
    assign pick_data   = letter_from_rand(lfsr_q[12:8], pick_upper);
    assign lfsr_unused = ^{lfsr_q[7:6], lfsr_q[13]};

    always_comb begin
        state_d      = state_q;
        do_reload    = 1'b0;
        do_dec       = 1'b0;
        do_pick      = 1'b0;
        do_clr_tries = 1'b0;
        do_inc_try   = 1'b0;
        do_spawn     = 1'b0;
        do_drop      = 1'b0;
        do_mark_hold = 1'b0;
        do_end_hold  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick && pause) begin
                    if (frames_cur == 5'd0) begin
                        state_d      = PICK;
                        do_clr_tries = 1'b1;
                    end else begin
                        do_dec = 1'b1;
                    end
                end
            end
            PICK: begin
                do_pick = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (vm.wr_ready) begin
                    do_spawn = 1'b1;
                    state_d  = HOLD;
                end else if (tries_inc == TRY_LAST) begin
                    do_drop   = 1'b1;
                    do_reload = 1'b1;
                    state_d   = IDLE;
                end else begin
                    do_inc_try = 1'b1;
                    state_d    = PICK;
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    if (hold_seen) begin
                        do_end_hold = 1'b1;
                        do_reload   = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        do_mark_hold = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_end_q     <= 1'b0;
            frames_left <= 5'd0;
            reload_q    <= 1'b1;
            tries       <= '0;
            hold_seen   <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= 8'h00;
            vel_q       <= 8'h00;
            spawn_count <= 14'd0;
            drop_count  <= 8'd0;
        end else begin
            v_end_q  <= v_end;
            reload_q <= 1'b0;

            if (do_reload) begin
                frames_left <= reload_val;
            end else if (do_dec) begin
                frames_left <= frames_cur - 5'd1;
            end else begin
                frames_left <= frames_cur;
            end

            if (do_clr_tries) begin
                tries <= '0;
            end else if (do_inc_try) begin
                tries <= tries_inc;
            end

            if (do_pick) begin
                addr_q <= pick_addr;
                data_q <= pick_data;
                vel_q  <= lfsr_q[15:8];
            end

            if (do_spawn) begin
                wren_q      <= 1'b1;
                hold_seen   <= 1'b0;
                spawn_count <= spawn_count + 14'd1;
            end else if (do_mark_hold) begin
                hold_seen <= 1'b1;
            end else if (do_end_hold) begin
                wren_q <= 1'b0;
            end

            if (do_drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign vm.vmdata_wren   = wren_q;
    assign vm.vmdata_wraddr = addr_q;
    assign vm.vmdata_wr     = data_q;
    assign vm.veldata_wr    = vel_q;

endmodule

// File: tb/tb_char_spawner.sv
`timescale 1ns/1ps
module tb_char_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        v_end = 1'b0;
    logic        pause = 1'b1;
    logic [1:0]  mode  = 2'd0;
    logic [13:0] spawn_count;
    logic [7:0]  drop_count;

    char_spawner_if vm_if ();

    char_spawner #(
        .MAX_TRIES (4),
        .SEED      (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .v_end       (v_end),
        .pause       (pause),
        .mode        (mode),
        .vm          (vm_if.master),
        .spawn_count (spawn_count),
        .drop_count  (drop_count)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR advanced alongside the design
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    typedef struct {
        int         cyc;
        logic [5:0] addr;
        logic [7:0] data;
        logic [7:0] vel;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic [15:0] r, input int c);
        exp_t       e;
        int         l;
        logic [7:0] base;
        e.cyc  = c;
        e.addr = 6'((r[5:0] % 52) + 1);
        l      = r[12:8] % 26;
        base   = 8'h61;
`ifdef SPAWN_UPPERCASE_EN
        if (r[13]) base = 8'h41;
`endif
        e.data = base + 8'(l);
        e.vel  = r[15:8];
        return e;
    endfunction

    // Output monitor: pops the scoreboard on each wren rising edge
    logic        prev_wren = 1'b0;
    int          rise_cyc  = -1;
    int          last_rise = -1;
    int          fall_cyc  = -1;
    logic [21:0] held;
    exp_t        mon_e;
    bit          in_range;

    initial forever begin
        @(posedge clk);
        #1;
        if (!reset) begin
            prev_wren = 1'b0;
        end else begin
            if (vm_if.vmdata_wren && !prev_wren) begin
                last_rise = rise_cyc;
                rise_cyc  = cyc;
                chk("spawn_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("spawn_cyc",  cyc, mon_e.cyc);
                    chk("spawn_addr", vm_if.vmdata_wraddr, mon_e.addr);
                    chk("spawn_data", vm_if.vmdata_wr, mon_e.data);
                    chk("spawn_vel",  vm_if.veldata_wr, mon_e.vel);
                end
                in_range = vm_if.vmdata_wr inside {[8'h61:8'h7A]};
`ifdef SPAWN_UPPERCASE_EN
                in_range = in_range || (vm_if.vmdata_wr inside {[8'h41:8'h5A]});
`endif
                chk("data_range", 32'(in_range), 1);
                chk("addr_range", 32'(vm_if.vmdata_wraddr inside {[6'd1:6'd52]}), 1);
                held = {vm_if.vmdata_wraddr, vm_if.vmdata_wr, vm_if.veldata_wr};
            end else if (vm_if.vmdata_wren && prev_wren) begin
                chk("hold_stable", {vm_if.vmdata_wraddr, vm_if.vmdata_wr, vm_if.veldata_wr}, held);
            end else if (!vm_if.vmdata_wren && prev_wren) begin
                fall_cyc = cyc;
            end
            prev_wren = vm_if.vmdata_wren;
        end
    end

    // One 12-clock frame; the tick is sampled on the first posedge
    task automatic frame(input bit spawn, output int tcyc);
        @(negedge clk);
        v_end = 1'b1;
        @(posedge clk);
        #1;
        tcyc = cyc;
        if (spawn) sb.push_back(predict(m_lfsr, cyc + 2));
        repeat (3) @(negedge clk);
        v_end = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frames(input int n);
        int t;
        for (int i = 0; i < n; i++) frame(1'b0, t);
    endtask

    task automatic spawn_frame();
        int t;
        frame(1'b1, t);
    endtask

    task automatic hold_exit();
        int t1, t2;
        frame(1'b0, t1);
        chk("wren_mid_hold", vm_if.vmdata_wren, 1);
        frame(1'b0, t2);
        chk("wren_fall_cyc", fall_cyc, t2);
        chk("wren_after_hold", vm_if.vmdata_wren, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        vm_if.wr_ready = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wren",  vm_if.vmdata_wren, 0);
        chk("rst_addr",  vm_if.vmdata_wraddr, 0);
        chk("rst_data",  vm_if.vmdata_wr, 0);
        chk("rst_vel",   vm_if.veldata_wr, 0);
        chk("rst_spawn", spawn_count, 0);
        chk("rst_drop",  drop_count, 0);
        reset = 1'b1;

        // mode 0: first spawn on the 32nd tick
        frames(31);
        spawn_frame();
        chk("spawn_count_1", spawn_count, 1);
        hold_exit();

        // mode change mid-interval only applies at the next reload
        frames(10);
        mode = 2'd3;
        frames(21);
        spawn_frame();
        chk("spawn_count_2", spawn_count, 2);
        hold_exit();

        // mode 3: rising edges 2 + 8 frames apart
        frames(7);
        spawn_frame();
        hold_exit();
        frames(7);
        spawn_frame();
        chk("spawn_spacing", rise_cyc - last_rise, 120);
        hold_exit();

        // pause freezes the countdown; pause during HOLD does not shorten it
        frames(3);
        pause = 1'b0;
        frames(100);
        chk("paused_spawn_count", spawn_count, 4);
        pause = 1'b1;
        frames(4);
        spawn_frame();
        pause = 1'b0;
        hold_exit();
        pause = 1'b1;
        chk("spawn_count_5", spawn_count, 5);

        // reset in the middle of HOLD
        frames(7);
        spawn_frame();
        chk("pre_reset_wren", vm_if.vmdata_wren, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_wren",  vm_if.vmdata_wren, 0);
        chk("reset_spawn", spawn_count, 0);
        chk("reset_drop",  drop_count, 0);
        mode           = 2'd3;
        vm_if.wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // occupied slots: 4 PICK/CHECK pairs, then one drop
        frames(7);
        @(negedge clk);
        v_end = 1'b1;
        @(posedge clk);
        #1;
        repeat (7) @(posedge clk);
        #1;
        chk("drop_before_4th", drop_count, 0);
        @(posedge clk);
        #1;
        chk("drop_after_4th", drop_count, 1);
        @(negedge clk);
        v_end = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 1; i < 300; i++) frames(8);
        chk("drop_saturated", drop_count, 255);
        chk("drop_no_spawn",  spawn_count, 0);
        chk("sb_drained",     sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
